// File: rtl/fft_pkg.sv
// Shared types and default widths for the FFT sample player.
package fft_pkg;

    localparam int SAMPLE_W     = 16;
    localparam int GAP_W_DEF    = 4;
    localparam int FRAMES_W_DEF = 8;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] re;
        logic signed [SAMPLE_W-1:0] im;
    } sample_t;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DRAIN
    } player_state_e;

endpackage

// File: rtl/fft_sample_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// Reads colliding with a write return the previous contents.
module fft_sample_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [2*DATA_W-1:0]        wr_data,
    input  logic                       rd_en,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [2*DATA_W-1:0]        rd_data
);

    logic [2*DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Read register doubles as the output data register, so it is cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fft_sample_player.sv
// Replays a RAM-resident complex frame with programmable gap, length and frame count.
module fft_sample_player
    import fft_pkg::*;
#(
    parameter int DATA_W   = SAMPLE_W,
    parameter int DEPTH    = 256,
    parameter int GAP_W    = GAP_W_DEF,
    parameter int FRAMES_W = FRAMES_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [$clog2(DEPTH)-1:0]    wr_addr,
    input  logic signed [DATA_W-1:0]    wr_re,
    input  logic signed [DATA_W-1:0]    wr_im,
    input  logic                        start,
    input  logic                        stop,
    input  logic [$clog2(DEPTH)-1:0]    len_m1,
    input  logic [GAP_W-1:0]            gap,
    input  logic [FRAMES_W-1:0]         frames,
    output logic signed [DATA_W-1:0]    data_re_o,
    output logic signed [DATA_W-1:0]    data_im_o,
    output logic                        valid_o,
    output logic                        sof_o,
    output logic                        eof_o,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int AW = $clog2(DEPTH);

    player_state_e        state, state_nx;
    logic [AW-1:0]        addr, len_l;
    logic [GAP_W-1:0]     gap_cnt, gap_l;
    logic [FRAMES_W-1:0]  frame_cnt, frames_l, frame_cnt_nx;
    logic                 stop_pend, launch, issue, last_addr, finish;
    logic                 vld_p1, sof_p1, eof_p1, done_p1;
    logic [2*DATA_W-1:0]  rd_word;

    assign launch       = (state == IDLE) && start && !stop;
    assign issue        = (state == PLAY) && (gap_cnt == '0);
    assign last_addr    = (addr == len_l);
    assign frame_cnt_nx = frame_cnt + 1'b1;
    // A stop arriving on the frame's last issue still ends playback there.
    assign finish       = issue && last_addr &&
                          (((frames_l != '0) && (frame_cnt_nx == frames_l)) || stop_pend || stop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (launch) state_nx = PLAY;
            PLAY:    if (finish) state_nx = DRAIN;
            DRAIN:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_l     <= '0;
            gap_l     <= '0;
            frames_l  <= '0;
            addr      <= '0;
            gap_cnt   <= '0;
            frame_cnt <= '0;
            stop_pend <= 1'b0;
        end else if (launch) begin
            len_l     <= len_m1;
            gap_l     <= gap;
            frames_l  <= frames;
            addr      <= '0;
            gap_cnt   <= '0;
            frame_cnt <= '0;
            stop_pend <= 1'b0;
        end else if (state == PLAY) begin
            if (stop)
                stop_pend <= 1'b1;
            if (issue) begin
                gap_cnt <= gap_l;
                if (last_addr) begin
                    addr      <= '0;
                    frame_cnt <= frame_cnt_nx;
                end else begin
                    addr <= addr + 1'b1;
                end
            end else begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    // Stage p1: flags registered alongside the RAM read of the issued address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            sof_p1  <= 1'b0;
            eof_p1  <= 1'b0;
            done_p1 <= 1'b0;
        end else begin
            vld_p1  <= issue;
            sof_p1  <= issue && (addr == '0);
            eof_p1  <= issue && last_addr;
            done_p1 <= finish;
        end
    end

    fft_sample_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data ({wr_re, wr_im}),
        .rd_en   (issue),
        .rd_addr (addr),
        .rd_data (rd_word)
    );

    assign data_re_o = rd_word[2*DATA_W-1:DATA_W];
    assign data_im_o = rd_word[DATA_W-1:0];
    assign valid_o   = vld_p1;
    assign sof_o     = sof_p1;
    assign eof_o     = eof_p1;
    assign done_o    = done_p1;
    assign busy_o    = (state != IDLE);

endmodule

// File: tb/tb_fft_sample_player.sv
// Directed bench for fft_sample_player with a cycle-stamped expected-sample scoreboard.
module tb_fft_sample_player;

    localparam int DATA_W   = 16;
    localparam int DEPTH    = 8;
    localparam int AW       = 3;
    localparam int GAP_W    = 4;
    localparam int FRAMES_W = 8;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b1;
    logic                       wr_en = 1'b0;
    logic [AW-1:0]              wr_addr = '0;
    logic signed [DATA_W-1:0]   wr_re = '0;
    logic signed [DATA_W-1:0]   wr_im = '0;
    logic                       start = 1'b0;
    logic                       stop = 1'b0;
    logic [AW-1:0]              len_m1 = '0;
    logic [GAP_W-1:0]           gap = '0;
    logic [FRAMES_W-1:0]        frames = '0;
    logic signed [DATA_W-1:0]   data_re_o, data_im_o;
    logic                       valid_o, sof_o, eof_o, busy_o, done_o;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t0 = 0;

    logic signed [DATA_W-1:0] m_re [DEPTH];
    logic signed [DATA_W-1:0] m_im [DEPTH];

    typedef struct {
        int                       cyc;
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
        logic                     sof;
        logic                     eof;
        logic                     done;
    } exp_t;

    exp_t sbq[$];

    fft_sample_player #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .GAP_W    (GAP_W),
        .FRAMES_W (FRAMES_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_re     (wr_re),
        .wr_im     (wr_im),
        .start     (start),
        .stop      (stop),
        .len_m1    (len_m1),
        .gap       (gap),
        .frames    (frames),
        .data_re_o (data_re_o),
        .data_im_o (data_im_o),
        .valid_o   (valid_o),
        .sof_o     (sof_o),
        .eof_o     (eof_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every valid sample must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && valid_o) begin
            if (sbq.size() == 0) begin
                chk("unexpected_valid", {31'b0, valid_o}, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("cycle", cyc, e.cyc);
                chk("re", data_re_o, e.re);
                chk("im", data_im_o, e.im);
                chk("sof", sof_o, e.sof);
                chk("eof", eof_o, e.eof);
                chk("done", done_o, e.done);
                chk("busy_with_valid", busy_o, 32'd1);
            end
        end else if (rst_n) begin
            chk("done_without_valid", done_o, 32'd0);
        end
    end

    task automatic wr(input int a, input int re, input int im);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a[AW-1:0];
        wr_re   = re[DATA_W-1:0];
        wr_im   = im[DATA_W-1:0];
        @(posedge clk);
        #1 wr_en = 1'b0;
        m_re[a] = re[DATA_W-1:0];
        m_im[a] = im[DATA_W-1:0];
    endtask

    task automatic launch(input int len, input int g, input int fr);
        @(negedge clk);
        len_m1 = len[AW-1:0];
        gap    = g[GAP_W-1:0];
        frames = fr[FRAMES_W-1:0];
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t0 = cyc;
    endtask

    task automatic push(input int len, input int g, input int f_first, input int nfr, input bit last_done);
        for (int f = f_first; f < f_first + nfr; f++) begin
            for (int a = 0; a <= len; a++) begin
                exp_t e;
                int idx;
                idx    = f * (len + 1) + a;
                e.cyc  = t0 + 1 + idx * (g + 1);
                e.re   = m_re[a];
                e.im   = m_im[a];
                e.sof  = (a == 0);
                e.eof  = (a == len);
                e.done = last_done && (f == f_first + nfr - 1) && (a == len);
                sbq.push_back(e);
            end
        end
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain", sbq.size(), 32'd0);
        chk("busy_on_done", busy_o, 32'd1);
        @(negedge clk);
        #1 chk("busy_after_done", busy_o, 32'd0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", valid_o, 32'd0);
        chk("rst_busy", busy_o, 32'd0);
        chk("rst_done", done_o, 32'd0);
        chk("rst_re", data_re_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) wr(i, 100 * i, -i);

        // Single frame back-to-back, with a start pulse while busy.
        launch(7, 0, 1);
        push(7, 0, 0, 1, 1'b1);
        wait_to(t0 + 3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(40);

        // Gap pacing over two frames; setting changes mid-play must not matter.
        launch(7, 1, 2);
        push(7, 1, 0, 2, 1'b1);
        wait_to(t0 + 5);
        len_m1 = 3'd3;
        gap    = 4'd3;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(80);

        // start together with stop in IDLE is ignored.
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        #1 chk("start_stop_busy", busy_o, 32'd0);
        repeat (3) @(negedge clk);
        #1 chk("start_stop_busy_later", busy_o, 32'd0);
        chk("start_stop_valid", valid_o, 32'd0);

        // Continuous playback, stop during the 4th sample of frame 2.
        launch(7, 0, 0);
        push(7, 0, 0, 2, 1'b1);
        wait_to(t0 + 12);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        drain(40);
        repeat (12) @(negedge clk);
        #1 chk("no_frame3_valid", valid_o, 32'd0);
        chk("no_frame3_busy", busy_o, 32'd0);

        // Reset mid-play while the 4th sample is on the output.
        launch(7, 0, 1);
        push(7, 0, 0, 1, 1'b1);
        wait_to(t0 + 4);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", valid_o, 32'd0);
        chk("mid_rst_sof", sof_o, 32'd0);
        chk("mid_rst_eof", eof_o, 32'd0);
        chk("mid_rst_busy", busy_o, 32'd0);
        chk("mid_rst_done", done_o, 32'd0);
        chk("mid_rst_re", data_re_o, 32'd0);
        chk("mid_rst_im", data_im_o, 32'd0);
        chk("mid_rst_remaining", sbq.size(), 32'd4);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        launch(7, 0, 1);
        push(7, 0, 0, 1, 1'b1);
        drain(40);

        // Full-scale samples and single-sample frames.
        wr(0, -32768, 32767);
        wr(1, 32767, -32768);
        launch(0, 0, 3);
        push(0, 0, 0, 3, 1'b1);
        drain(40);
        launch(1, 2, 1);
        push(1, 2, 0, 1, 1'b1);
        drain(40);

        // Write to the address being issued: old data now, new data next frame.
        launch(7, 0, 2);
        push(7, 0, 0, 1, 1'b0);
        wait_to(t0 + 5);
        wr_en   = 1'b1;
        wr_addr = 3'd5;
        wr_re   = 16'sd1234;
        wr_im   = -16'sd4321;
        @(posedge clk);
        #1 wr_en = 1'b0;
        m_re[5] = 16'sd1234;
        m_im[5] = -16'sd4321;
        push(7, 0, 1, 1, 1'b1);
        drain(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

endmodule
